// File: rtl/decode_scoreboard_stage_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, ID/EX outputs and statistics.
// cntrl layout: [2:0] aluop, [3] rs2 select (1=register, 0=immediate),
//               [4] regWrite, [5] memWriteEnable, [6] wbMux (1=ALU, 0=memory), [7] jump.
interface decode_scoreboard_stage_if #(
  parameter int DATA      = 32,
  parameter int ADD_WIDTH = 32,
  parameter int REG_NUM   = 32,
  parameter int CNT_W     = 32
);
  localparam int REG_WIDTH = $clog2(REG_NUM);

  // IF/ID side
  logic                 valid_i;
  logic [31:0]          instruction;
  logic [ADD_WIDTH-1:0] pc;
  logic                 is_taken;
  // writeback port
  logic                 wr_en;
  logic [REG_WIDTH-1:0] wr_addr;
  logic [DATA-1:0]      wr_data;
  // ID/EX side
  logic                 stall_o;
  logic                 valid_o;
  logic [7:0]           cntrl;
  logic [DATA-1:0]      imm_o;
  logic [DATA-1:0]      read_data1;
  logic [DATA-1:0]      read_data2;
  logic [REG_WIDTH-1:0] rs1;
  logic [REG_WIDTH-1:0] rs2;
  logic [REG_WIDTH-1:0] rd;
  logic [ADD_WIDTH-1:0] pc_o;
  logic                 halt_o;
  // statistics
  logic [CNT_W-1:0]     stat_total;
  logic [CNT_W-1:0]     stat_arith;
  logic [CNT_W-1:0]     stat_logic;
  logic [CNT_W-1:0]     stat_mem;
  logic [CNT_W-1:0]     stat_branch;
  logic [CNT_W-1:0]     stat_stalls;
  logic [CNT_W-1:0]     stat_hazards;

  modport master (
    output valid_i, instruction, pc, is_taken, wr_en, wr_addr, wr_data,
    input  stall_o, valid_o, cntrl, imm_o, read_data1, read_data2, rs1, rs2, rd,
           pc_o, halt_o, stat_total, stat_arith, stat_logic, stat_mem,
           stat_branch, stat_stalls, stat_hazards
  );

  modport slave (
    input  valid_i, instruction, pc, is_taken, wr_en, wr_addr, wr_data,
    output stall_o, valid_o, cntrl, imm_o, read_data1, read_data2, rs1, rs2, rd,
           pc_o, halt_o, stat_total, stat_arith, stat_logic, stat_mem,
           stat_branch, stat_stalls, stat_hazards
  );
endinterface

// File: rtl/decode_scoreboard_stage.sv
// MIPS-lite ID stage: decode, write-through register file, per-register
// scoreboard for RAW hazards, bubble issue, sticky HALT and saturating stats.
module decode_scoreboard_stage #(
  parameter int DATA      = 32,
  parameter int ADD_WIDTH = 32,
  parameter int REG_NUM   = 32,
  parameter int WB_LAT    = 3,
  parameter int FORWARD   = 0,
  parameter int CNT_W     = 32
) (
  input logic clock,
  input logic rst,
  decode_scoreboard_stage_if.slave bus
);
  localparam int         REG_WIDTH = $clog2(REG_NUM);
  localparam logic [2:0] LAT       = 3'(WB_LAT);

  localparam logic [5:0] OP_LDW  = 6'h0C;
  localparam logic [5:0] OP_STW  = 6'h0D;
  localparam logic [5:0] OP_BZ   = 6'h0E;
  localparam logic [5:0] OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_JR   = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h11;

  // instruction fields
  logic [5:0]           w_op;
  logic [REG_WIDTH-1:0] w_rs_f, w_rt_f, w_rd_f;
  assign w_op   = bus.instruction[31:26];
  assign w_rs_f = bus.instruction[21 +: REG_WIDTH];
  assign w_rt_f = bus.instruction[16 +: REG_WIDTH];
  assign w_rd_f = bus.instruction[11 +: REG_WIDTH];

  // decoded fields
  logic                 w_legal, w_use1, w_use2, w_load, w_halt;
  logic                 w_arith, w_logic, w_mem, w_branch;
  logic [REG_WIDTH-1:0] w_dest;
  logic [2:0]           w_aluop;
  logic                 w_rs2sel, w_regwr, w_memwe, w_wbmux, w_jump;
  logic [7:0]           w_cntrl;

  // Opcode decode: classes, used sources, destination and control bits
  always_comb begin
    w_legal  = 1'b0;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_load   = 1'b0;
    w_halt   = 1'b0;
    w_arith  = 1'b0;
    w_logic  = 1'b0;
    w_mem    = 1'b0;
    w_branch = 1'b0;
    w_dest   = '0;
    w_aluop  = 3'd0;
    w_rs2sel = 1'b0;
    w_regwr  = 1'b0;
    w_memwe  = 1'b0;
    w_wbmux  = 1'b0;
    w_jump   = 1'b0;
    if (w_op <= 6'h0B) begin
      w_legal = 1'b1;
      w_use1  = 1'b1;
      w_regwr = 1'b1;
      w_wbmux = 1'b1;
      if (w_op <= 6'h05) begin
        w_arith = 1'b1;
        w_aluop = w_op[3:1];
      end else begin
        w_logic = 1'b1;
        w_aluop = 3'd3 + 3'((w_op - 6'd6) >> 1);
      end
      // odd opcodes take the immediate and write rt
      if (w_op[0]) begin
        w_dest = w_rt_f;
      end else begin
        w_rs2sel = 1'b1;
        w_use2   = 1'b1;
        w_dest   = w_rd_f;
      end
    end else begin
      case (w_op)
        OP_LDW: begin
          w_legal = 1'b1; w_mem = 1'b1; w_use1 = 1'b1;
          w_dest  = w_rt_f; w_regwr = 1'b1; w_load = 1'b1;
        end
        OP_STW: begin
          w_legal = 1'b1; w_mem = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
          w_memwe = 1'b1;
        end
        OP_BZ: begin
          w_legal = 1'b1; w_branch = 1'b1; w_use1 = 1'b1; w_aluop = 3'd6;
        end
        OP_BEQ: begin
          w_legal = 1'b1; w_branch = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
          w_aluop = 3'd7; w_rs2sel = 1'b1;
        end
        OP_JR: begin
          w_legal = 1'b1; w_branch = 1'b1; w_use1 = 1'b1; w_jump = 1'b1;
        end
        OP_HALT: begin
          w_legal = 1'b1; w_halt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_cntrl = {w_jump, w_wbmux, w_memwe, w_regwr, w_rs2sel, w_aluop};

  // source indices collapse to R0 when unused, which can never hazard
  logic [REG_WIDTH-1:0] w_s1, w_s2;
  assign w_s1 = w_use1 ? w_rs_f : '0;
  assign w_s2 = w_use2 ? w_rt_f : '0;

  logic [2:0]      w_busy [REG_NUM];
  logic            w_ld   [REG_NUM];
  logic [DATA-1:0] w_regs [REG_NUM];

  logic r_halt, r_stall_q;
  logic w_haz1, w_haz2, w_active, w_stall, w_issue;

  // RAW check: wait for writeback, or only for a load whose data is not yet forwardable
  always_comb begin
    if (FORWARD == 0) begin
      w_haz1 = (w_s1 != '0) && (w_busy[w_s1] != 3'd0);
      w_haz2 = (w_s2 != '0) && (w_busy[w_s2] != 3'd0);
    end else begin
      w_haz1 = (w_s1 != '0) && w_ld[w_s1] && (w_busy[w_s1] == LAT);
      w_haz2 = (w_s2 != '0) && w_ld[w_s2] && (w_busy[w_s2] == LAT);
    end
  end

  assign w_active = bus.valid_i && !bus.is_taken && !r_halt;
  assign w_stall  = w_active && (w_haz1 || w_haz2);
  assign w_issue  = w_active && !(w_haz1 || w_haz2) && w_legal;

  // per-register storage and scoreboard entry; R0 is constant zero
  genvar gi;
  for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
    if (gi == 0) begin : g_r0
      assign w_busy[gi] = 3'd0;
      assign w_ld[gi]   = 1'b0;
      assign w_regs[gi] = '0;
    end else begin : g_rn
      logic [2:0]      r_busy;
      logic            r_ld;
      logic [DATA-1:0] r_data;
      logic            w_set, w_wr;
      assign w_set = w_issue && (w_dest == REG_WIDTH'(gi));
      assign w_wr  = bus.wr_en && (bus.wr_addr == REG_WIDTH'(gi));

      // New issue reloads the countdown (wins over decrement); writeback stores data
      always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
          r_busy <= 3'd0;
          r_ld   <= 1'b0;
          r_data <= '0;
        end else begin
          if (w_set) begin
            r_busy <= LAT;
            r_ld   <= w_load;
          end else if (r_busy != 3'd0) begin
            r_busy <= r_busy - 3'd1;
          end
          if (w_wr) r_data <= bus.wr_data;
        end
      end

      assign w_busy[gi] = r_busy;
      assign w_ld[gi]   = r_ld;
      assign w_regs[gi] = r_data;
    end
  end

  // write-through read: a same-cycle writeback to a source is seen immediately
  logic [DATA-1:0] w_rd1, w_rd2;
  assign w_rd1 = (bus.wr_en && (bus.wr_addr != '0) && (bus.wr_addr == w_s1)) ? bus.wr_data : w_regs[w_s1];
  assign w_rd2 = (bus.wr_en && (bus.wr_addr != '0) && (bus.wr_addr == w_s2)) ? bus.wr_data : w_regs[w_s2];

  logic                 r_valid;
  logic [7:0]           r_cntrl;
  logic [DATA-1:0]      r_imm, r_rd1, r_rd2;
  logic [REG_WIDTH-1:0] r_rs1, r_rs2, r_rd;
  logic [ADD_WIDTH-1:0] r_pc;

  // ID/EX register: bubbles carry no side-effecting control; HALT is sticky
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_cntrl   <= 8'd0;
      r_imm     <= '0;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_pc      <= '0;
      r_halt    <= 1'b0;
      r_stall_q <= 1'b0;
    end else begin
      r_valid   <= w_issue;
      r_cntrl   <= w_issue ? w_cntrl : 8'd0;
      r_imm     <= {{(DATA-16){bus.instruction[15]}}, bus.instruction[15:0]};
      r_rd1     <= w_rd1;
      r_rd2     <= w_rd2;
      r_rs1     <= w_s1;
      r_rs2     <= w_s2;
      r_rd      <= w_dest;
      r_pc      <= bus.pc;
      r_stall_q <= w_stall;
      if (w_issue && w_halt) r_halt <= 1'b1;
    end
  end

  // statistics: total, arith, logic, mem, branch, stall cycles, stalled instructions
  logic [6:0]       w_inc;
  logic [CNT_W-1:0] w_cnt [7];
  assign w_inc = {w_stall && !r_stall_q, w_stall, w_issue && w_branch, w_issue && w_mem,
                  w_issue && w_logic, w_issue && w_arith, w_issue};

  for (gi = 0; gi < 7; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    // Saturating event counter
    always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (w_inc[gi] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
    assign w_cnt[gi] = r_cnt;
  end

  assign bus.stall_o      = w_stall;
  assign bus.valid_o      = r_valid;
  assign bus.cntrl        = r_cntrl;
  assign bus.imm_o        = r_imm;
  assign bus.read_data1   = r_rd1;
  assign bus.read_data2   = r_rd2;
  assign bus.rs1          = r_rs1;
  assign bus.rs2          = r_rs2;
  assign bus.rd           = r_rd;
  assign bus.pc_o         = r_pc;
  assign bus.halt_o       = r_halt;
  assign bus.stat_total   = w_cnt[0];
  assign bus.stat_arith   = w_cnt[1];
  assign bus.stat_logic   = w_cnt[2];
  assign bus.stat_mem     = w_cnt[3];
  assign bus.stat_branch  = w_cnt[4];
  assign bus.stat_stalls  = w_cnt[5];
  assign bus.stat_hazards = w_cnt[6];
endmodule

// File: tb/tb_decode_scoreboard_stage.sv
// Directed bench: dut0 is non-forwarding with 4-bit counters, dut1 forwards
// with 32-bit counters; both see identical stimulus.
module tb_decode_scoreboard_stage;
  localparam int DATA = 32;
  localparam int AW   = 32;
  localparam int RN   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decode_scoreboard_stage_if #(.DATA(DATA), .ADD_WIDTH(AW), .REG_NUM(RN), .CNT_W(4))  if0();
  decode_scoreboard_stage_if #(.DATA(DATA), .ADD_WIDTH(AW), .REG_NUM(RN), .CNT_W(32)) if1();

  decode_scoreboard_stage #(.DATA(DATA), .ADD_WIDTH(AW), .REG_NUM(RN), .WB_LAT(3),
                            .FORWARD(0), .CNT_W(4))
    u_dut0 (.clock(clk), .rst(rst_n), .bus(if0));

  decode_scoreboard_stage #(.DATA(DATA), .ADD_WIDTH(AW), .REG_NUM(RN), .WB_LAT(3),
                            .FORWARD(1), .CNT_W(32))
    u_dut1 (.clock(clk), .rst(rst_n), .bus(if1));

  assign if1.valid_i     = if0.valid_i;
  assign if1.instruction = if0.instruction;
  assign if1.pc          = if0.pc;
  assign if1.is_taken    = if0.is_taken;
  assign if1.wr_en       = if0.wr_en;
  assign if1.wr_addr     = if0.wr_addr;
  assign if1.wr_data     = if0.wr_data;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("  ok   %s = 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr);
    if0.valid_i     = 1'b1;
    if0.instruction = instr;
    if0.pc          = if0.pc + 32'd4;
  endtask

  task automatic idle();
    if0.valid_i  = 1'b0;
    if0.is_taken = 1'b0;
    if0.wr_en    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, n1;
    logic [31:0] pc_add;
    if0.instruction = 32'd0;
    if0.pc          = 32'h100;
    if0.wr_addr     = '0;
    if0.wr_data     = '0;
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("rst valid_o", if0.valid_o, 0);
    chk("rst stall_o", if0.stall_o, 0);
    chk("rst halt_o", if0.halt_o, 0);
    chk("rst stat_total", if0.stat_total, 0);
    chk("rst pc_o", if0.pc_o, 0);
    cyc();
    rst_n = 1'b1;

    // ADDI r1,r0,5 then ADD r2,r1,r1
    drive(itype(6'h01, 5'd0, 5'd1, 16'd5));
    #4 chk("t1 addi stall", if0.stall_o, 0);
    cyc();
    chk("t1 addi valid", if0.valid_o, 1);
    chk("t1 addi rd", if0.rd, 1);
    chk("t1 addi imm", if0.imm_o, 5);
    chk("t1 addi cntrl", if0.cntrl, 8'h50);
    drive(rtype(6'h00, 5'd1, 5'd1, 5'd2));
    pc_add = if0.pc;
    n0 = 0;
    for (int k = 0; k < 8; k++) begin
      #4;
      chk("t1 fwd no stall", if1.stall_o, 0);
      if (!if0.stall_o) break;
      n0++;
      cyc();
    end
    chk("t1 stall cycles", n0, 3);
    if0.wr_en = 1'b1; if0.wr_addr = 5'd1; if0.wr_data = 32'd5;
    cyc();
    chk("t1 add valid", if0.valid_o, 1);
    chk("t1 add rd", if0.rd, 2);
    chk("t1 add rs1", if0.rs1, 1);
    chk("t1 add rs2", if0.rs2, 1);
    chk("t1 add rdata1", if0.read_data1, 5);
    chk("t1 add rdata2", if0.read_data2, 5);
    chk("t1 add cntrl", if0.cntrl, 8'h58);
    chk("t1 add pc", if0.pc_o, pc_add);
    chk("t1 stat_stalls", if0.stat_stalls, 3);
    chk("t1 stat_hazards", if0.stat_hazards, 1);
    chk("t1 stat_total", if0.stat_total, 2);
    chk("t1 stat_arith", if0.stat_arith, 2);
    idle();

    // LDW r1 then ADD r2,r1,r1
    do_reset();
    drive(itype(6'h0C, 5'd0, 5'd1, 16'h10));
    cyc();
    chk("t2 ldw cntrl", if1.cntrl, 8'h10);
    drive(rtype(6'h00, 5'd1, 5'd1, 5'd2));
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      #4;
      if (!if0.stall_o && !if1.stall_o) break;
      n0 += int'(if0.stall_o);
      n1 += int'(if1.stall_o);
      cyc();
    end
    chk("t2 fwd load-use stalls", n1, 1);
    chk("t2 nofwd stalls", n0, 3);
    cyc();
    chk("t2 add valid", if0.valid_o, 1);
    chk("t2 fwd stat_stalls", if1.stat_stalls, 1);
    chk("t2 fwd stat_hazards", if1.stat_hazards, 1);
    chk("t2 fwd stat_mem", if1.stat_mem, 1);
    idle();

    // write-through bypass and R0
    do_reset();
    if0.wr_en = 1'b1; if0.wr_addr = 5'd4; if0.wr_data = 32'hDEAD;
    drive(rtype(6'h00, 5'd4, 5'd0, 5'd5));
    cyc();
    chk("t3 bypass rdata1", if0.read_data1, 32'hDEAD);
    chk("t3 bypass rs1", if0.rs1, 4);
    chk("t3 r0 rdata2", if0.read_data2, 0);
    if0.wr_addr = 5'd0; if0.wr_data = 32'hBEEF;
    drive(rtype(6'h00, 5'd0, 5'd4, 5'd6));
    cyc();
    chk("t3 r0 write ignored", if0.read_data1, 0);
    chk("t3 stored rdata2", if0.read_data2, 32'hDEAD);
    idle();

    // is_taken flushes a stalled instruction
    do_reset();
    drive(itype(6'h01, 5'd0, 5'd1, 16'd7));
    cyc();
    drive(rtype(6'h00, 5'd1, 5'd1, 5'd2));
    #4 chk("t4 stalled", if0.stall_o, 1);
    cyc();
    if0.is_taken = 1'b1;
    #4 chk("t4 flush stall_o", if0.stall_o, 0);
    cyc();
    chk("t4 flush valid", if0.valid_o, 0);
    chk("t4 flush cntrl", if0.cntrl, 0);
    chk("t4 flush total", if0.stat_total, 1);
    chk("t4 flush stalls", if0.stat_stalls, 1);
    chk("t4 flush hazards", if0.stat_hazards, 1);
    if0.is_taken = 1'b0;
    n0 = 0;
    for (int k = 0; k < 8; k++) begin
      #4;
      if (!if0.stall_o) break;
      n0++;
      cyc();
    end
    chk("t4 residual stalls", n0, 1);
    cyc();
    chk("t4 reissue valid", if0.valid_o, 1);
    chk("t4 reissue total", if0.stat_total, 2);
    chk("t4 reissue hazards", if0.stat_hazards, 2);
    idle();

    // HALT is sticky and suppresses stalls
    do_reset();
    drive(itype(6'h01, 5'd0, 5'd1, 16'd1));
    cyc();
    drive(itype(6'h11, 5'd0, 5'd0, 16'd0));
    cyc();
    chk("t5 halt_o", if0.halt_o, 1);
    drive(rtype(6'h00, 5'd1, 5'd1, 5'd2));
    #4 chk("t5 no stall after halt", if0.stall_o, 0);
    cyc();
    chk("t5 add ignored", if0.valid_o, 0);
    cyc();
    chk("t5 halt sticky", if0.halt_o, 1);
    chk("t5 stat_total", if0.stat_total, 2);
    idle();

    // asynchronous reset in the middle of a stall
    do_reset();
    chk("t5 halt cleared", if0.halt_o, 0);
    drive(itype(6'h01, 5'd0, 5'd1, 16'd1));
    cyc();
    drive(rtype(6'h00, 5'd1, 5'd1, 5'd2));
    #4 chk("t5 pre-reset stall", if0.stall_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t5 async stall_o", if0.stall_o, 0);
    chk("t5 async valid_o", if0.valid_o, 0);
    chk("t5 async rd", if0.rd, 0);
    chk("t5 async total", if0.stat_total, 0);
    #1 rst_n = 1'b1;
    chk("t5 post-reset stall", if0.stall_o, 0);
    cyc();
    chk("t5 post-reset issue", if0.valid_o, 1);
    chk("t5 post-reset rd", if0.rd, 2);
    idle();

    // illegal opcode bubble, then counter saturation
    do_reset();
    drive(itype(6'h3F, 5'd0, 5'd0, 16'd0));
    cyc();
    chk("t6 illegal valid", if0.valid_o, 0);
    chk("t6 illegal total", if0.stat_total, 0);
    drive(itype(6'h01, 5'd0, 5'd0, 16'd1));
    for (int k = 0; k < 15; k++) cyc();
    chk("t6 total at 15", if0.stat_total, 15);
    chk("t6 arith at 15", if0.stat_arith, 15);
    for (int k = 0; k < 3; k++) cyc();
    chk("t6 total saturated", if0.stat_total, 15);
    chk("t6 wide total", if1.stat_total, 18);
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
